// File: rtl/mdu_iter_if.sv
// Handshake and operand bundle between the EX stage and the multiply/divide unit.
// Signal names mirror the unit's port list so both sides read the same.
interface mdu_iter_if #(
    parameter int XLEN = 64
);
    logic            valid_i;
    logic [2:0]      op_i;
    logic            word_i;
    logic [XLEN-1:0] a_i;
    logic [XLEN-1:0] b_i;
    logic            accept_i;
    logic            flush_i;
    logic            ok_o;
    logic [XLEN-1:0] result_o;

    modport master (
        output valid_i, op_i, word_i, a_i, b_i,
        output accept_i, flush_i,
        input  ok_o, result_o
    );

    modport slave (
        input  valid_i, op_i, word_i, a_i, b_i,
        input  accept_i, flush_i,
        output ok_o, result_o
    );
endinterface

// File: rtl/mdu_iter.sv
// Iterative RV64M multiply/divide unit for the EX stage.
// ok_o stays low while a result is pending so the hazard unit can stall.
module mdu_iter #(
    parameter int XLEN = 64,
    parameter int WLEN = 32
) (
    input  logic      clk,
    input  logic      resetn,
    mdu_iter_if.slave bus
);
    localparam int CW = $clog2(XLEN) + 1;

    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_e;

    state_e          state_q, state_d;
    logic [XLEN-1:0] q_q, q_d;
    logic [XLEN-1:0] d_q, d_d;
    logic [XLEN-1:0] r_q, r_d;
    logic [XLEN-1:0] res_q, res_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2:0]      op_q, op_d;
    logic            word_q, word_d;
    logic            sa_q, sa_d;
    logic            sb_q, sb_d;

    function automatic logic [XLEN-1:0] wfix(
        input logic            w,
        input logic [XLEN-1:0] x
    );
        wfix = w ? {{(XLEN-WLEN){x[WLEN-1]}}, x[WLEN-1:0]} : x;
    endfunction

    logic            sgn, a_neg, b_neg, div0, ovf;
    logic [XLEN-1:0] a_w, b_w, a_mag, b_mag, min_w;

    // Operands brought to operating width for a new divide
    always_comb begin
        sgn   = ~bus.op_i[0];
        a_w   = bus.word_i
              ? {{(XLEN-WLEN){sgn & bus.a_i[WLEN-1]}}, bus.a_i[WLEN-1:0]}
              : bus.a_i;
        b_w   = bus.word_i
              ? {{(XLEN-WLEN){sgn & bus.b_i[WLEN-1]}}, bus.b_i[WLEN-1:0]}
              : bus.b_i;
        a_neg = sgn & a_w[XLEN-1];
        b_neg = sgn & b_w[XLEN-1];
        a_mag = a_neg ? -a_w : a_w;
        b_mag = b_neg ? -b_w : b_w;
        min_w = bus.word_i ? ({XLEN{1'b1}} << (WLEN-1))
                           : ({XLEN{1'b1}} << (XLEN-1));
        div0  = (b_w == '0);
        ovf   = sgn & (a_w == min_w) & (&b_w);
    end

    logic [2*XLEN-1:0] pa, pb, prod;

    assign pa   = {{XLEN{sa_q & q_q[XLEN-1]}}, q_q};
    assign pb   = {{XLEN{sb_q & d_q[XLEN-1]}}, d_q};
    assign prod = pa * pb;

    logic [XLEN:0]   rem_sh, diff;
    logic [XLEN-1:0] quo_n, rem_n, quo_s, rem_s;
    logic            last;

    // One restoring step; word dividends are pre-shifted to the top
    assign rem_sh = {r_q, q_q[XLEN-1]};
    assign diff   = rem_sh - {1'b0, d_q};
    assign quo_n  = {q_q[XLEN-2:0], ~diff[XLEN]};
    assign rem_n  = diff[XLEN] ? rem_sh[XLEN-1:0] : diff[XLEN-1:0];
    assign quo_s  = (sa_q ^ sb_q) ? -quo_n : quo_n;
    assign rem_s  = sa_q ? -rem_n : rem_n;
    assign last   = cnt_q == (word_q ? CW'(WLEN-1) : CW'(XLEN-1));

    always_comb begin
        state_d = state_q;
        q_d     = q_q;
        d_d     = d_q;
        r_d     = r_q;
        res_d   = res_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        word_d  = word_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        unique case (state_q)
            IDLE: begin
                if (bus.valid_i && !bus.flush_i) begin
                    op_d   = bus.op_i;
                    word_d = bus.word_i;
                    cnt_d  = '0;
                    if (!bus.op_i[2]) begin
                        q_d     = bus.a_i;
                        d_d     = bus.b_i;
                        sa_d    = bus.op_i != 3'd3;
                        sb_d    = ~bus.op_i[1];
                        state_d = MUL;
                    end else if (div0 || ovf) begin
                        if (div0)
                            res_d = bus.op_i[1] ? wfix(bus.word_i, a_w) : '1;
                        else
                            res_d = bus.op_i[1] ? '0 : wfix(bus.word_i, a_w);
                        state_d = DONE;
                    end else begin
                        q_d     = bus.word_i ? a_mag << (XLEN-WLEN) : a_mag;
                        d_d     = b_mag;
                        r_d     = '0;
                        sa_d    = a_neg;
                        sb_d    = b_neg;
                        state_d = DIV;
                    end
                end
            end
            MUL: begin
                if (word_q)
                    res_d = wfix(1'b1, prod[XLEN-1:0]);
                else if (op_q == 3'd0)
                    res_d = prod[XLEN-1:0];
                else
                    res_d = prod[2*XLEN-1:XLEN];
                state_d = DONE;
            end
            DIV: begin
                q_d   = quo_n;
                r_d   = rem_n;
                cnt_d = cnt_q + 1'b1;
                if (last) begin
                    res_d   = op_q[1] ? wfix(word_q, rem_s)
                                      : wfix(word_q, quo_s);
                    state_d = DONE;
                end
            end
            DONE: begin
                if (bus.accept_i)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (bus.flush_i)
            state_d = IDLE;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= IDLE;
            q_q     <= '0;
            d_q     <= '0;
            r_q     <= '0;
            res_q   <= '0;
            cnt_q   <= '0;
            op_q    <= '0;
            word_q  <= 1'b0;
            sa_q    <= 1'b0;
            sb_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            q_q     <= q_d;
            d_q     <= d_d;
            r_q     <= r_d;
            res_q   <= res_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            word_q  <= word_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
        end
    end

    assign bus.ok_o     = ~bus.valid_i | (state_q == DONE);
    assign bus.result_o = res_q;
endmodule

// File: tb/tb_mdu_iter.sv
// Bench for mdu_iter: directed vector table, multi-cycle corner sequences,
// and random ops checked against an arithmetic reference model.
module tb_mdu_iter;
    logic clk = 1'b0;
    logic resetn;

    always #5 clk = ~clk;

    mdu_iter_if #(.XLEN(64)) bus ();

    mdu_iter #(.XLEN(64), .WLEN(32)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    int n_pass = 0;
    int n_total = 0;

    typedef struct {
        logic [2:0]  op;
        logic        w;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] exp;
        int          lat;
        string       name;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        n_total++;
        if (act === exp)
            n_pass++;
        else
            $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic logic [63:0] sx32(input logic [31:0] x);
        return {{32{x[31]}}, x};
    endfunction

    function automatic logic [63:0] ref_res(input logic [2:0] op,
        input logic w, input logic [63:0] a, input logic [63:0] b);
        logic signed [127:0] xa, xb;
        logic [127:0] p;
        longint sa, sb;
        int sa32, sb32;
        logic [31:0] ua32, ub32;
        logic ov64, ov32;
        sa = a;
        sb = b;
        sa32 = a[31:0];
        sb32 = b[31:0];
        ua32 = a[31:0];
        ub32 = b[31:0];
        xa = sa;
        xb = sb;
        ov64 = (a == 64'h8000_0000_0000_0000) && (b == '1);
        ov32 = (ua32 == 32'h8000_0000) && (ub32 == '1);
        if (!op[2]) begin
            if (w) return sx32(ua32 * ub32);
            case (op[1:0])
                2'd0: return a * b;
                2'd1: p = xa * xb;
                2'd2: p = xa * {64'h0, b};
                default: p = {64'h0, a} * {64'h0, b};
            endcase
            return p[127:64];
        end
        if (w) begin
            case (op[1:0])
                2'd0: return (ub32 == 0) ? '1 : ov32 ? sx32(ua32)
                           : sx32(32'(sa32 / sb32));
                2'd1: return (ub32 == 0) ? '1 : sx32(ua32 / ub32);
                2'd2: return (ub32 == 0) ? sx32(ua32) : ov32 ? '0
                           : sx32(32'(sa32 % sb32));
                default: return (ub32 == 0) ? sx32(ua32)
                              : sx32(ua32 % ub32);
            endcase
        end
        case (op[1:0])
            2'd0: return (b == 0) ? '1 : ov64 ? a : 64'(sa / sb);
            2'd1: return (b == 0) ? '1 : a / b;
            2'd2: return (b == 0) ? a : ov64 ? '0 : 64'(sa % sb);
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int ref_lat(input logic [2:0] op, input logic w,
        input logic [63:0] a, input logic [63:0] b);
        logic sg;
        sg = ~op[0];
        if (!op[2]) return 2;
        if (w) begin
            if (b[31:0] == 0) return 1;
            if (sg && a[31:0] == 32'h8000_0000 && b[31:0] == '1) return 1;
            return 33;
        end
        if (b == 0) return 1;
        if (sg && a == 64'h8000_0000_0000_0000 && b == '1) return 1;
        return 65;
    endfunction

    // Issue one op with accept held high; operands are scrambled once taken
    task automatic run_op(input logic [2:0] op, input logic w,
        input logic [63:0] a, input logic [63:0] b, input string name,
        output logic [63:0] res, output int lat);
        @(negedge clk);
        bus.op_i     = op;
        bus.word_i   = w;
        bus.a_i      = a;
        bus.b_i      = b;
        bus.valid_i  = 1'b1;
        bus.accept_i = 1'b1;
        #1;
        lat = 0;
        while (!bus.ok_o && lat < 200) begin
            @(negedge clk);
            bus.a_i = {$urandom, $urandom};
            bus.b_i = {$urandom, $urandom};
            #1;
            lat++;
        end
        res = bus.result_o;
        @(negedge clk);
        #1;
        check({name, "_idle"}, 64'(bus.ok_o), 64'd0);
        bus.valid_i = 1'b0;
    endtask

    logic [63:0] res, exp;
    int lat, elat;
    logic [2:0] rop;
    logic rw;
    logic [63:0] ra, rb;

    initial begin
        resetn       = 1'b0;
        bus.valid_i  = 1'b0;
        bus.op_i     = '0;
        bus.word_i   = 1'b0;
        bus.a_i      = '0;
        bus.b_i      = '0;
        bus.accept_i = 1'b1;
        bus.flush_i  = 1'b0;

        vecs.push_back('{3'd0, 1'b0, 64'd3, 64'hFFFF_FFFF_FFFF_FFFB,
                         64'hFFFF_FFFF_FFFF_FFF1, 2, "mul"});
        vecs.push_back('{3'd3, 1'b0, '1, '1,
                         64'hFFFF_FFFF_FFFF_FFFE, 2, "mulhu"});
        vecs.push_back('{3'd2, 1'b0, '1, 64'd2, '1, 2, "mulhsu"});
        vecs.push_back('{3'd1, 1'b0, '1, '1, 64'd0, 2, "mulh"});
        vecs.push_back('{3'd0, 1'b1, 64'h7FFF_FFFF, 64'd2,
                         64'hFFFF_FFFF_FFFF_FFFE, 2, "mulw"});
        vecs.push_back('{3'd4, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2,
                         64'hFFFF_FFFF_FFFF_FFFD, 65, "div"});
        vecs.push_back('{3'd6, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2,
                         '1, 65, "rem"});
        vecs.push_back('{3'd6, 1'b1, 64'h0000_0001_FFFF_FFF9, 64'd2,
                         '1, 33, "remw"});
        vecs.push_back('{3'd5, 1'b0, 64'd123, 64'd0, '1, 1, "divu0"});
        vecs.push_back('{3'd4, 1'b0, 64'h8000_0000_0000_0000, '1,
                         64'h8000_0000_0000_0000, 1, "div_ovf"});
        vecs.push_back('{3'd6, 1'b0, 64'h8000_0000_0000_0000, '1,
                         64'd0, 1, "rem_ovf"});
        vecs.push_back('{3'd5, 1'b0, 64'd100, 64'd7, 64'd14, 65, "divu"});
        vecs.push_back('{3'd5, 1'b1, 64'hFFFF_FFFF, 64'd1, '1, 33,
                         "divuw"});
        vecs.push_back('{3'd4, 1'b1, 64'h8000_0000, 64'hFFFF_FFFF,
                         64'hFFFF_FFFF_8000_0000, 1, "divw_ovf"});
        vecs.push_back('{3'd7, 1'b1, 64'h1234_8000_0000, 64'h5_0000_0000,
                         64'hFFFF_FFFF_8000_0000, 1, "remuw0"});

        repeat (3) @(negedge clk);
        #1;
        check("rst_ok", 64'(bus.ok_o), 64'd1);
        check("rst_res", bus.result_o, 64'd0);
        resetn = 1'b1;

        foreach (vecs[i]) begin
            run_op(vecs[i].op, vecs[i].w, vecs[i].a, vecs[i].b,
                   vecs[i].name, res, lat);
            check({vecs[i].name, "_res"}, res, vecs[i].exp);
            check({vecs[i].name, "_lat"}, 64'(lat), 64'(vecs[i].lat));
        end

        // Result held while EX is stalled, then back-to-back restart
        @(negedge clk);
        bus.op_i     = 3'd4;
        bus.word_i   = 1'b0;
        bus.a_i      = 64'hFFFF_FFFF_FFFF_FFF9;
        bus.b_i      = 64'd2;
        bus.valid_i  = 1'b1;
        bus.accept_i = 1'b0;
        #1;
        lat = 0;
        while (!bus.ok_o && lat < 200) begin
            @(negedge clk);
            #1;
            lat++;
        end
        check("stall_lat", 64'(lat), 64'd65);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            bus.a_i = {$urandom, $urandom};
            #1;
            check("stall_ok", 64'(bus.ok_o), 64'd1);
            check("stall_res", bus.result_o, 64'hFFFF_FFFF_FFFF_FFFD);
        end
        bus.accept_i = 1'b1;
        @(negedge clk);
        #1;
        check("b2b_ok_low", 64'(bus.ok_o), 64'd0);
        bus.valid_i = 1'b0;
        bus.flush_i = 1'b1;
        @(negedge clk);
        #1;
        bus.flush_i = 1'b0;
        check("b2b_flush_ok", 64'(bus.ok_o), 64'd1);

        // Flush at cycle 20 of a divide
        @(negedge clk);
        bus.op_i    = 3'd4;
        bus.a_i     = 64'd1000;
        bus.b_i     = 64'd3;
        bus.valid_i = 1'b1;
        repeat (20) @(negedge clk);
        #1;
        check("flush_busy", 64'(bus.ok_o), 64'd0);
        bus.flush_i = 1'b1;
        bus.valid_i = 1'b0;
        @(negedge clk);
        #1;
        bus.flush_i = 1'b0;
        check("flush_ok", 64'(bus.ok_o), 64'd1);
        run_op(3'd5, 1'b0, 64'd100, 64'd7, "postflush", res, lat);
        check("postflush_res", res, 64'd14);
        check("postflush_lat", 64'(lat), 64'd65);

        // Reset at cycle 10 of a divide
        @(negedge clk);
        bus.op_i    = 3'd4;
        bus.a_i     = 64'd999;
        bus.b_i     = 64'd5;
        bus.valid_i = 1'b1;
        repeat (10) @(negedge clk);
        resetn      = 1'b0;
        bus.valid_i = 1'b0;
        @(negedge clk);
        #1;
        resetn = 1'b1;
        check("midrst_ok", 64'(bus.ok_o), 64'd1);
        check("midrst_res", bus.result_o, 64'd0);
        run_op(3'd5, 1'b0, 64'd1000, 64'd10, "postrst", res, lat);
        check("postrst_res", res, 64'd100);
        check("postrst_lat", 64'(lat), 64'd65);

        // Random ops against the reference model
        for (int i = 0; i < 80; i++) begin
            rop = 3'($urandom_range(0, 7));
            rw  = ($urandom_range(0, 3) == 0);
            if (rw && rop inside {3'd1, 3'd2, 3'd3}) rop = 3'd0;
            ra = {$urandom, $urandom};
            rb = {$urandom, $urandom};
            case ($urandom_range(0, 7))
                0: rb = rw ? {$urandom, 32'h0} : 64'd0;
                1: begin
                    rb = '1;
                    ra = rw ? {$urandom, 32'h8000_0000}
                            : 64'h8000_0000_0000_0000;
                end
                2: rb = 64'($urandom_range(1, 15));
                default: ;
            endcase
            exp  = ref_res(rop, rw, ra, rb);
            elat = ref_lat(rop, rw, ra, rb);
            run_op(rop, rw, ra, rb, "rnd", res, lat);
            check("rnd_res", res, exp);
            check("rnd_lat", 64'(lat), 64'(elat));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
